fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline. It produces the IF/ID pipeline register (PC_pype0, PCp4_pype0, Instraction_pype) consumed by decode. It issues in-order requests to the instruction memory over a req/gnt/rvalid handshake and buffers returned words. It absorbs decode stalls (keep) and PC redirects from the early-branch path in decode and the late branch/jump path in later stages.

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_stage_fifo.sv | 60 ++++++
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the RV32I fetch stage.
// Holds the opcode map and the reset/bubble defaults used by fetch_stage.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF        = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF        = 32'h0000_0013;
    localparam int          MAX_OUTSTANDING_DEF = 2;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'h03,
        OPC_OPIMM  = 7'h13,
        OPC_AUIPC  = 7'h17,
        OPC_STORE  = 7'h23,
        OPC_OP     = 7'h33,
        OPC_LUI    = 7'h37,
        OPC_BRANCH = 7'h63,
        OPC_JALR   = 7'h67,
        OPC_JAL    = 7'h6F
    } opcode_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// Two-entry {pc,inst} response buffer between the instruction memory and IF/ID.
// Flush has priority over push/pop; storage itself is not reset.
module fetch_fifo (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] rdata_o,
    output logic [1:0]  count_o,
    output logic        empty_o,
    output logic        full_o
);

    logic [63:0] mem_q [2];
    logic        wptr_q, wptr_d;
    logic        rptr_q, rptr_d;
    logic [1:0]  count_q, count_d;
    logic        push_ok;
    logic        pop_ok;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q ^ push_ok;
        rptr_d  = rptr_q ^ pop_ok;
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        if (flush_i) begin
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: credit-limited in-order imem requests, response
// buffering, stale-response dropping after redirects, and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST        = NOP_INST_DEF,
    parameter int          MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        branch_PC_early_contral,
    input  logic [31:0] branch_PC_early,
    input  logic        branch_PC_late_contral,
    input  logic [31:0] branch_PC_late,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_pype0,
    output logic [31:0] PCp4_pype0,
    output logic [31:0] Instraction_pype,
    output logic        fetch_valid
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]   pc_id_q, pc_id_d;
    logic [31:0]   pcp4_id_q, pcp4_id_d;
    logic [31:0]   inst_id_q, inst_id_d;
    logic          valid_id_q, valid_id_d;

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [CW:0]   credits_used;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_drop;
    logic          rsp_take;
    logic          bypass;
    logic          fifo_push;
    logic          fifo_pop;
    logic [63:0]   fifo_rdata;
    logic [1:0]    fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    assign redirect    = branch_PC_late_contral || branch_PC_early_contral;
    assign redirect_pc = branch_PC_late_contral ? branch_PC_late : branch_PC_early;

    assign credits_used = (CW+1)'(outstanding_q) + (CW+1)'(fifo_count);
    assign imem_req     = rst && !redirect && (credits_used < (CW+1)'(MAX_OUTSTANDING));
    assign imem_addr    = fetch_pc_q;
    assign req_fire     = imem_req && imem_gnt;

    // A response with nothing in flight is a leftover from before a reset.
    assign rsp_fire = imem_rvalid && (outstanding_q != '0);
    assign rsp_drop = rsp_fire && (drop_cnt_q != '0);
    assign rsp_take = rsp_fire && (drop_cnt_q == '0);

    assign fifo_pop  = !redirect && !keep && !fifo_empty;
    assign bypass    = !redirect && !keep && fifo_empty && rsp_take;
    assign fifo_push = rsp_take && !redirect && !bypass && !fifo_full;

    fetch_fifo u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (redirect),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({resp_pc_q, imem_rdata}),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        drop_cnt_d    = drop_cnt_q - CW'(rsp_drop);
        fetch_pc_d    = req_fire ? pc_plus4(fetch_pc_q) : fetch_pc_q;
        resp_pc_d     = rsp_take ? pc_plus4(resp_pc_q) : resp_pc_q;
        if (redirect) begin
            // everything still in flight belongs to the abandoned path
            drop_cnt_d = outstanding_d;
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
        end
    end

    always_comb begin
        pc_id_d    = pc_id_q;
        pcp4_id_d  = pcp4_id_q;
        inst_id_d  = inst_id_q;
        valid_id_d = valid_id_q;
        if (redirect) begin
            inst_id_d  = NOP_INST;
            valid_id_d = 1'b0;
        end else if (!keep) begin
            if (!fifo_empty) begin
                pc_id_d    = fifo_rdata[63:32];
                pcp4_id_d  = pc_plus4(fifo_rdata[63:32]);
                inst_id_d  = fifo_rdata[31:0];
                valid_id_d = 1'b1;
            end else if (bypass) begin
                pc_id_d    = resp_pc_q;
                pcp4_id_d  = pc_plus4(resp_pc_q);
                inst_id_d  = imem_rdata;
                valid_id_d = 1'b1;
            end else begin
                inst_id_d  = NOP_INST;
                valid_id_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            pc_id_q       <= 32'd0;
            pcp4_id_q     <= 32'd0;
            inst_id_q     <= NOP_INST;
            valid_id_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            pc_id_q       <= pc_id_d;
            pcp4_id_q     <= pcp4_id_d;
            inst_id_q     <= inst_id_d;
            valid_id_q    <= valid_id_d;
        end
    end

    assign PC_pype0         = pc_id_q;
    assign PCp4_pype0       = pcp4_id_q;
    assign Instraction_pype = inst_id_q;
    assign fetch_valid      = valid_id_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-configurable memory model plus a queue-based
// reference of the fetch stream, checked every cycle and at scenario points.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, keep, e_ctl, l_ctl;
    logic [31:0] e_pc, l_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC_pype0, PCp4_pype0, Instraction_pype;
    logic        fetch_valid;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk                     (clk),
        .rst                     (rst),
        .keep                    (keep),
        .branch_PC_early_contral (e_ctl),
        .branch_PC_early         (e_pc),
        .branch_PC_late_contral  (l_ctl),
        .branch_PC_late          (l_pc),
        .imem_req                (imem_req),
        .imem_addr               (imem_addr),
        .imem_gnt                (imem_gnt),
        .imem_rvalid             (imem_rvalid),
        .imem_rdata              (imem_rdata),
        .PC_pype0                (PC_pype0),
        .PCp4_pype0              (PCp4_pype0),
        .Instraction_pype        (Instraction_pype),
        .fetch_valid             (fetch_valid)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // memory model
    int unsigned lat = 1;
    int unsigned gnt_pct = 100;
    bit          data_is_addr = 1'b1;
    typedef struct {int due; logic [31:0] data;} mem_rsp_t;
    mem_rsp_t mq[$];

    // reference model
    typedef struct {logic [31:0] addr; bit stale;} inflight_t;
    inflight_t   m_infl[$];
    logic [63:0] m_buf[$];
    logic [31:0] m_pc = RST_PC;
    logic [31:0] e_pc_out = 32'd0, e_pcp4 = 32'd0, e_inst = NOP;
    logic        e_valid = 1'b0;
    logic        exp_req, obs_req;
    logic [31:0] exp_addr, obs_addr;

    function automatic logic [129:0] obs_vec();
        return {obs_req, obs_addr, PC_pype0, PCp4_pype0, Instraction_pype, fetch_valid};
    endfunction

    function automatic logic [129:0] exp_vec();
        return {exp_req, exp_addr, e_pc_out, e_pcp4, e_inst, e_valid};
    endfunction

    task automatic model_step();
        bit          redir, have;
        logic [63:0] resp;
        inflight_t   r;
        exp_addr = m_pc;
        have = 1'b0;
        resp = '0;
        if (!rst) begin
            exp_req = 1'b0;
            m_pc = RST_PC;
            m_infl.delete();
            m_buf.delete();
            e_pc_out = 32'd0; e_pcp4 = 32'd0; e_inst = NOP; e_valid = 1'b0;
            return;
        end
        redir   = e_ctl || l_ctl;
        exp_req = !redir && ((m_infl.size() + m_buf.size()) < 2);
        if (imem_rvalid && m_infl.size() > 0) begin
            r = m_infl.pop_front();
            if (!r.stale) begin
                have = 1'b1;
                resp = {r.addr, imem_rdata};
            end
        end
        if (exp_req && imem_gnt) begin
            m_infl.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_buf.delete();
            m_pc   = l_ctl ? l_pc : e_pc;
            e_inst = NOP; e_valid = 1'b0;
        end else if (keep) begin
            if (have) m_buf.push_back(resp);
        end else if (m_buf.size() > 0) begin
            {e_pc_out, e_inst} = m_buf.pop_front();
            e_pcp4 = e_pc_out + 32'd4; e_valid = 1'b1;
            if (have) m_buf.push_back(resp);
        end else if (have) begin
            {e_pc_out, e_inst} = resp;
            e_pcp4 = e_pc_out + 32'd4; e_valid = 1'b1;
        end else begin
            e_inst = NOP; e_valid = 1'b0;
        end
    endtask

    // One clock: drive memory, sample pre-edge handshake, advance model, step past edge.
    task automatic tick();
        mem_rsp_t ent;
        logic [31:0] rnd;
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].data;
        end
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        model_step();
        @(posedge clk);
        if (obs_req && imem_gnt) begin
            rnd = $urandom();
            ent.due  = cyc + int'(lat);
            ent.data = data_is_addr ? obs_addr : rnd;
            mq.push_back(ent);
        end
        if (imem_rvalid) void'(mq.pop_front());
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; keep = 1'b0; e_ctl = 1'b0; l_ctl = 1'b0;
        e_pc = 32'd0; l_pc = 32'd0;
        tick();
        tick();
        tests++;
        if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_vec cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
        end
        tests++;
        if ({obs_req, PC_pype0, PCp4_pype0, Instraction_pype, fetch_valid} !== {1'b0, 32'd0, 32'd0, NOP, 1'b0}) begin
            fails++;
            $display("FAIL reset_values req=%b pc=%h pcp4=%h inst=%h v=%b", obs_req, PC_pype0, PCp4_pype0, Instraction_pype, fetch_valid);
        end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL stream_vec cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (k >= 1) begin
                tests++;
                if ({PC_pype0, PCp4_pype0, Instraction_pype, fetch_valid} !==
                    {32'((k-1)*4), 32'((k-1)*4 + 4), 32'((k-1)*4), 1'b1}) begin
                    fails++;
                    $display("FAIL stream_pc k=%0d got pc=%h pcp4=%h inst=%h v=%b", k, PC_pype0, PCp4_pype0, Instraction_pype, fetch_valid);
                end
            end
        end
    endtask

    task automatic test_keep();
        bit          saw_low = 1'b0;
        int          seen = 0;
        logic [31:0] want = 32'h0000_000C;
        keep = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (!obs_req) saw_low = 1'b1;
            tests++;
            if (obs_vec() !== exp_vec() || PC_pype0 !== 32'h8 || fetch_valid !== 1'b1) begin
                fails++;
                $display("FAIL keep_hold cyc=%0d got pc=%h v=%b vec %h want pc=00000008 v=1 vec %h", cyc, PC_pype0, fetch_valid, obs_vec(), exp_vec());
            end
        end
        tests++;
        if (!saw_low) begin
            fails++;
            $display("FAIL keep_credit req stayed 1 want a 0 while credits full");
        end
        keep = 1'b0;
        for (int k = 0; k < 10 && seen < 2; k++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL keep_vec cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (fetch_valid) begin
                tests++;
                if (PC_pype0 !== want || Instraction_pype !== want) begin
                    fails++;
                    $display("FAIL keep_resume got pc=%h inst=%h want %h", PC_pype0, Instraction_pype, want);
                end
                want = want + 32'd4;
                seen++;
            end
        end
        tests++;
        if (seen < 2) begin
            fails++;
            $display("FAIL keep_timeout got %0d valid want 2", seen);
        end
    endtask

    task automatic wait_two_inflight(input string name);
        int k = 0;
        while (m_infl.size() != 2 && k < 20) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL %s_fill cyc=%0d got %h want %h", name, cyc, obs_vec(), exp_vec());
            end
            k++;
        end
        tests++;
        if (m_infl.size() != 2) begin
            fails++;
            $display("FAIL %s_fill_timeout inflight=%0d want 2", name, m_infl.size());
        end
    endtask

    task automatic test_redirect_drop();
        bit got = 1'b0;
        lat = 2;
        wait_two_inflight("drop");
        e_ctl = 1'b1; e_pc = 32'h100;
        tick();
        e_ctl = 1'b0;
        tests++;
        if (obs_vec() !== exp_vec() || obs_req !== 1'b0 || fetch_valid !== 1'b0) begin
            fails++;
            $display("FAIL drop_redirect cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
        end
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL drop_vec cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (fetch_valid) begin
                got = 1'b1;
                tests++;
                if (PC_pype0 !== 32'h100 || Instraction_pype !== 32'h100) begin
                    fails++;
                    $display("FAIL drop_first got pc=%h inst=%h want 00000100", PC_pype0, Instraction_pype);
                end
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL drop_timeout got no valid want pc 00000100");
        end
        lat = 1;
    endtask

    task automatic test_dual_redirect();
        bit got = 1'b0;
        keep = 1'b1; e_ctl = 1'b1; e_pc = 32'h200; l_ctl = 1'b1; l_pc = 32'h300;
        tick();
        keep = 1'b0; e_ctl = 1'b0; l_ctl = 1'b0;
        tests++;
        if (obs_vec() !== exp_vec() || fetch_valid !== 1'b0 || Instraction_pype !== NOP) begin
            fails++;
            $display("FAIL dual_bubble got v=%b inst=%h want v=0 inst=%h", fetch_valid, Instraction_pype, NOP);
        end
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL dual_vec cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (fetch_valid) begin
                got = 1'b1;
                tests++;
                if (PC_pype0 !== 32'h300) begin
                    fails++;
                    $display("FAIL dual_first got pc=%h want 00000300", PC_pype0);
                end
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL dual_timeout got no valid want pc 00000300");
        end
    endtask

    task automatic test_gnt_stall();
        logic [31:0] a0, pc0;
        gnt_pct = 0;
        tick();
        tick();
        a0  = m_pc;
        pc0 = e_pc_out;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec() || obs_req !== 1'b1 || obs_addr !== a0 ||
                fetch_valid !== 1'b0 || PC_pype0 !== pc0) begin
                fails++;
                $display("FAIL gnt_stall cyc=%0d got req=%b addr=%h v=%b pc=%h want 1 %h 0 %h", cyc, obs_req, obs_addr, fetch_valid, PC_pype0, a0, pc0);
            end
        end
        gnt_pct = 100;
    endtask

    task automatic test_wrap();
        bit got = 1'b0;
        e_ctl = 1'b1; e_pc = 32'hFFFF_FFF8;
        tick();
        e_ctl = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL wrap_vec cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (fetch_valid && PC_pype0 == 32'hFFFF_FFFC) begin
                got = 1'b1;
                tests++;
                if (PCp4_pype0 !== 32'd0) begin
                    fails++;
                    $display("FAIL wrap_pcp4 got %h want 00000000", PCp4_pype0);
                end
                tick();
                tests++;
                if (fetch_valid !== 1'b1 || PC_pype0 !== 32'd0 || Instraction_pype !== 32'd0) begin
                    fails++;
                    $display("FAIL wrap_next got v=%b pc=%h inst=%h want 1 00000000 00000000", fetch_valid, PC_pype0, Instraction_pype);
                end
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL wrap_timeout got no pc fffffffc want one");
        end
    endtask

    task automatic test_reset_mid();
        bit got = 1'b0;
        lat = 2;
        wait_two_inflight("rstmid");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tests++;
        if (obs_vec() !== exp_vec() ||
            {obs_req, PC_pype0, PCp4_pype0, Instraction_pype, fetch_valid} !== {1'b0, 32'd0, 32'd0, NOP, 1'b0}) begin
            fails++;
            $display("FAIL rstmid_values got req=%b pc=%h pcp4=%h inst=%h v=%b", obs_req, PC_pype0, PCp4_pype0, Instraction_pype, fetch_valid);
        end
        gnt_pct = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec() || obs_req !== 1'b1 || obs_addr !== RST_PC || fetch_valid !== 1'b0) begin
                fails++;
                $display("FAIL rstmid_stale cyc=%0d got req=%b addr=%h v=%b want 1 %h 0", cyc, obs_req, obs_addr, fetch_valid, RST_PC);
            end
        end
        gnt_pct = 100;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL rstmid_vec cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (fetch_valid) begin
                got = 1'b1;
                tests++;
                if (PC_pype0 !== RST_PC || Instraction_pype !== RST_PC) begin
                    fails++;
                    $display("FAIL rstmid_first got pc=%h inst=%h want %h", PC_pype0, Instraction_pype, RST_PC);
                end
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL rstmid_timeout got no valid want pc %h", RST_PC);
        end
        lat = 1;
    endtask

    task automatic test_random();
        logic [31:0] t0, t1;
        int unsigned r;
        data_is_addr = 1'b0;
        gnt_pct = 70;
        for (int k = 0; k < 400; k++) begin
            if (k % 100 == 0) lat = 1 + (k / 100) % 3;
            r  = $urandom_range(99);
            t0 = $urandom();
            t1 = $urandom();
            rst   = ($urandom_range(99) != 0);
            keep  = ($urandom_range(3) == 0);
            e_ctl = (r < 6);
            l_ctl = (r >= 3 && r < 9);
            e_pc  = {t0[31:2], 2'b00};
            l_pc  = {t1[31:2], 2'b00};
            tick();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random_vec cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
        end
        rst = 1'b1; keep = 1'b0; e_ctl = 1'b0; l_ctl = 1'b0;
        gnt_pct = 100; lat = 1; data_is_addr = 1'b1;
    endtask

    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_keep();
        test_redirect_drop();
        test_dual_redirect();
        test_gnt_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
